ram_port_ctrl: RTL and testbench

Processor-side I/O port controller sitting directly upstream of the two-bank RAM selector. Decodes processor `port_id`/strobe cycles into an address register, a bank/control register, and a data port, and generates the single-cycle write strobe and bank select that the selector turns into per-bank write enables. Also runs a prefetch state machine so that reads of the data port return a byte already fetched from the selected bank, with optional address auto-increment for block transfers.

---
 rtl/ram_port_ctrl.sv | 86 ++++++++
 tb/tb_ram_port_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ram_port_ctrl.sv
// ram_port_ctrl: processor port decoder driving the two-bank RAM selector with
// write strobes and a prefetch engine for reads of the data port.
module ram_port_ctrl #(
    parameter logic [7:0] BASE_PORT = 8'h10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       write_strobe_in,
    input  logic       read_strobe_in,
    output logic [7:0] in_port,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_wdata,
    output logic       ram_we,
    output logic       ram_re,
    output logic       ram_sel,
    input  logic [7:0] ram_rdata_1,
    input  logic [7:0] ram_rdata_2
);
    typedef enum logic [1:0] {FETCH, CAPTURE, VALID, WRITE} state_t;

    state_t     state, state_n;
    logic [7:0] addr, wbyte, rbuf, off;
    logic       bank, auto_inc, hit, wr, rd, wr_addr, wr_ctrl, wr_data, rd_valid, consume;

    assign off      = port_id - BASE_PORT;
    assign hit      = off < 8'd4;
    assign wr       = write_strobe_in && hit;
    assign rd       = read_strobe_in && !write_strobe_in && hit;
    assign wr_addr  = wr && off[1:0] == 2'd0;
    assign wr_ctrl  = wr && off[1:0] == 2'd1;
    assign wr_data  = wr && off[1:0] == 2'd2;
    assign rd_valid = state == VALID;
    assign consume  = rd && off[1:0] == 2'd2 && rd_valid;

    assign ram_addr  = addr;
    assign ram_wdata = wbyte;
    assign ram_sel   = bank;
    assign ram_we    = state == WRITE;
    assign ram_re    = state == FETCH && reset_n;

    // Next state: prefetch sequence, overridden by any invalidating strobe.
    always_comb begin
        state_n = state == FETCH ? CAPTURE : state == WRITE ? FETCH : VALID;
        if (wr_data)
            state_n = WRITE;
        else if (wr_addr || wr_ctrl || (consume && auto_inc))
            state_n = FETCH;
    end

    // Register file, state, and read buffer; capture only when not cancelled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= FETCH;
            addr     <= 8'h00;
            bank     <= 1'b0;
            auto_inc <= 1'b1;
            rbuf     <= 8'h00;
            wbyte    <= 8'h00;
        end else begin
            state <= state_n;
            if (wr_addr)
                addr <= out_port;
            else if (auto_inc && (state == WRITE || consume))
                addr <= addr + 8'd1;
            if (wr_ctrl) begin
                bank     <= out_port[0];
                auto_inc <= out_port[1];
            end
            if (wr_data)
                wbyte <= out_port;
            if (state == CAPTURE && state_n == VALID)
                rbuf <= bank ? ram_rdata_2 : ram_rdata_1;
        end
    end

    // Read mux back to the processor, zero-latency from port_id.
    always_comb begin
        in_port = !hit              ? 8'h00 :
                  off[1:0] == 2'd0  ? addr :
                  off[1:0] == 2'd1  ? {6'b0, auto_inc, bank} :
                  off[1:0] == 2'd2  ? rbuf :
                                      {5'b0, state == WRITE, bank, rd_valid};
    end
endmodule

// File: tb/tb_ram_port_ctrl.sv
// tb_ram_port_ctrl: directed bench for ram_port_ctrl with a two-bank synchronous RAM model.
module tb_ram_port_ctrl;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] port_id = 8'h00;
    logic [7:0] out_port = 8'h00;
    logic       write_strobe_in = 1'b0;
    logic       read_strobe_in = 1'b0;
    logic [7:0] in_port, ram_addr, ram_wdata, ram_rdata_1, ram_rdata_2;
    logic       ram_we, ram_re, ram_sel;
    logic [7:0] mem1 [256];
    logic [7:0] mem2 [256];
    int         checks = 0;
    int         failures = 0;
    int         re_cnt = 0;
    int         rc0;

    ram_port_ctrl dut (
        .clk(clk), .reset_n(reset_n), .port_id(port_id), .out_port(out_port),
        .write_strobe_in(write_strobe_in), .read_strobe_in(read_strobe_in),
        .in_port(in_port), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .ram_re(ram_re), .ram_sel(ram_sel),
        .ram_rdata_1(ram_rdata_1), .ram_rdata_2(ram_rdata_2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) begin
            if (ram_sel) mem2[ram_addr] <= ram_wdata;
            else         mem1[ram_addr] <= ram_wdata;
        end
        if (ram_re) begin
            ram_rdata_1 <= mem1[ram_addr];
            ram_rdata_2 <= mem2[ram_addr];
        end
    end

    always @(posedge clk) if (ram_re) re_cnt <= re_cnt + 1;

    always @(negedge clk) begin
        if (reset_n) begin
            checks++;
            assert (!(ram_we && ram_re)) else begin
                failures++;
                $error("FAIL we_re_exclusive got=%b%b exp=not both", ram_we, ram_re);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic rdp(input logic [7:0] pid, input string tag, input logic [7:0] exp);
        port_id = pid;
        #1;
        chk(tag, in_port, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [7:0] pid, input logic [7:0] d, input logic ws, input logic rs);
        port_id = pid;
        out_port = d;
        write_strobe_in = ws;
        read_strobe_in = rs;
        tick();
        write_strobe_in = 1'b0;
        read_strobe_in = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        port_id = 8'h13;
        #1;
        while (in_port[0] !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk(tag, {7'b0, in_port[0]}, 8'h01);
    endtask

    task automatic read_data(input string tag, input logic [7:0] exp);
        port_id = 8'h12;
        read_strobe_in = 1'b1;
        #1;
        chk(tag, in_port, exp);
        tick();
        read_strobe_in = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rdp(8'h11, "rst_ctrl", 8'h02);
        rdp(8'h10, "rst_addr", 8'h00);
        chk("rst_re_low", {7'b0, ram_re}, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_re_high", {7'b0, ram_re}, 8'h01);
        chk("rst_fetch_addr", ram_addr, 8'h00);
        tick();
        rdp(8'h13, "status_capture", 8'h00);
        tick();
        rdp(8'h13, "status_valid", 8'h01);
        rdp(8'h14, "unmapped_hi", 8'h00);

        step(8'h10, 8'h40, 1'b1, 1'b0);
        rdp(8'h10, "addr_wr", 8'h40);
        step(8'h11, 8'h03, 1'b1, 1'b0);
        rdp(8'h11, "ctrl_wr", 8'h03);
        chk("sel_bank2", {7'b0, ram_sel}, 8'h01);
        step(8'h12, 8'hA5, 1'b1, 1'b0);
        chk("we1", {7'b0, ram_we}, 8'h01);
        chk("we1_addr", ram_addr, 8'h40);
        chk("we1_data", ram_wdata, 8'hA5);
        rdp(8'h13, "status_busy", 8'h06);
        step(8'h12, 8'h5A, 1'b1, 1'b0);
        chk("we2", {7'b0, ram_we}, 8'h01);
        chk("we2_re", {7'b0, ram_re}, 8'h00);
        chk("we2_addr", ram_addr, 8'h41);
        chk("we2_data", ram_wdata, 8'h5A);
        tick();
        chk("we_done", {7'b0, ram_we}, 8'h00);
        rdp(8'h10, "addr_after_wr", 8'h42);

        step(8'h10, 8'hFF, 1'b1, 1'b0);
        step(8'h12, 8'h11, 1'b1, 1'b0);
        chk("wrap_we_addr", ram_addr, 8'hFF);
        chk("wrap_we_data", ram_wdata, 8'h11);
        tick();
        rdp(8'h10, "addr_wrap", 8'h00);
        rdp(8'h11, "bank_kept", 8'h03);

        step(8'h11, 8'h02, 1'b1, 1'b0);
        step(8'h10, 8'h10, 1'b1, 1'b0);
        step(8'h12, 8'hC3, 1'b1, 1'b0);
        step(8'h12, 8'h3C, 1'b1, 1'b0);
        tick();
        step(8'h10, 8'h10, 1'b1, 1'b0);
        wait_valid("valid_pre1");
        read_data("rd1", 8'hC3);
        rdp(8'h13, "status_consumed", 8'h00);
        wait_valid("valid_pre2");
        read_data("rd2", 8'h3C);
        rdp(8'h10, "addr_after_rd", 8'h12);

        step(8'h10, 8'h11, 1'b1, 1'b0);
        wait_valid("valid_pre3");
        step(8'h10, 8'h10, 1'b1, 1'b0);
        rc0 = re_cnt;
        read_data("stale_rd", 8'h3C);
        rdp(8'h10, "addr_no_adv", 8'h10);
        wait_valid("valid_pre4");
        chk("single_fetch", 8'(re_cnt - rc0), 8'h01);
        rdp(8'h12, "fresh_rbuf", 8'hC3);

        step(8'h12, 8'h77, 1'b1, 1'b1);
        chk("both_we", {7'b0, ram_we}, 8'h01);
        chk("both_data", ram_wdata, 8'h77);
        rdp(8'h10, "both_addr", 8'h10);
        tick();
        rdp(8'h10, "both_addr_inc", 8'h11);
        wait_valid("valid_pre5");
        step(8'h10, 8'h10, 1'b1, 1'b0);
        tick();
        step(8'h10, 8'h11, 1'b1, 1'b0);
        rdp(8'h12, "cancel_rbuf", 8'h3C);
        chk("cancel_re", {7'b0, ram_re}, 8'h01);
        chk("cancel_addr", ram_addr, 8'h11);
        step(8'h14, 8'hAA, 1'b1, 1'b0);
        rdp(8'h10, "unmapped_wr", 8'h11);
        rdp(8'h0F, "unmapped_lo", 8'h00);
        wait_valid("valid_pre6");
        step(8'h13, 8'hFF, 1'b1, 1'b0);
        rdp(8'h13, "status_ro", 8'h01);
        rdp(8'h12, "final_rbuf", 8'h3C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
